fft_frame_scheduler: RTL and testbench



---
 rtl/fft_sched_pkg.sv | 34 +++
 rtl/fft_frame_scheduler_rx.sv | 81 ++++++++
 rtl/fft_frame_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the FFT frame scheduler.
package fft_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SEND
  } sched_state_t;

  typedef enum logic [2:0] {
    P_READ,
    P_LATCH,
    P_ISSUE,
    P_WAIT_HI,
    P_WAIT_LO
  } send_phase_t;

  localparam logic [3:0] LED_IDLE = 4'b0001;
  localparam logic [3:0] LED_LOAD = 4'b0010;
  localparam logic [3:0] LED_RUN  = 4'b0100;
  localparam logic [3:0] LED_SEND = 4'b1000;

  // Bytes that make up one real sample of the given width.
  function automatic int smp_bytes(input int width);
    return width / 8;
  endfunction

  // Bytes sent per complex result bin (real part then imaginary part).
  function automatic int res_bytes(input int width);
    return 2 * (width / 8);
  endfunction

endpackage

// File: rtl/fft_frame_scheduler_rx.sv
// Builds signed samples from the MSB-first byte stream and numbers them within a frame.
module rx_sample_assembler
  import fft_sched_pkg::*;
#(
  parameter int bit_width = 24,
  parameter int N         = 16,
  parameter int LOGN      = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 smp_valid,
  output logic [bit_width-1:0] smp_data,
  output logic [LOGN-1:0]      smp_idx,
  output logic                 frame_done
);

  localparam int SMP_BYTES = smp_bytes(bit_width);
  localparam int BCNT_W    = (SMP_BYTES > 1) ? $clog2(SMP_BYTES) : 1;

  logic [BCNT_W-1:0]    byte_cnt;
  logic [LOGN-1:0]      smp_cnt;
  logic [bit_width-1:0] shift_next;
  logic                 accept;
  logic                 last_byte;

  assign accept    = en && rx_valid;
  assign last_byte = (byte_cnt == BCNT_W'(SMP_BYTES - 1));

  generate
    if (bit_width > 8) begin : g_multi
      logic [bit_width-9:0] partial_q;

      // Keep the leading bytes of the sample currently being received.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          partial_q <= '0;
        end else if (accept) begin
          partial_q <= shift_next[bit_width-9:0];
        end
      end

      assign shift_next = {partial_q, rx_byte};
    end else begin : g_single
      assign shift_next = rx_byte;
    end
  endgenerate

  // Count bytes per sample, emit the sample strobe, and flag the last sample of the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      smp_cnt    <= '0;
      smp_valid  <= 1'b0;
      smp_data   <= '0;
      smp_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      smp_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (frame_done) begin
        smp_idx <= '0;
      end
      if (accept) begin
        if (last_byte) begin
          byte_cnt   <= '0;
          smp_valid  <= 1'b1;
          smp_data   <= shift_next;
          smp_idx    <= smp_cnt;
          smp_cnt    <= smp_cnt + 1'b1;
          frame_done <= (smp_cnt == LOGN'(N - 1));
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frame sequencer: loads N samples from the UART, runs the FFT, and streams all results back out.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int bit_width = 24,
  parameter int N         = 16,
  parameter int LOGN      = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 enable,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 smp_valid,
  output logic [bit_width-1:0] smp_data,
  output logic [LOGN-1:0]      smp_idx,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic                 res_rd_en,
  output logic [LOGN-1:0]      res_rd_addr,
  input  logic [bit_width-1:0] res_re,
  input  logic [bit_width-1:0] res_im,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  input  logic                 tx_busy,
  output logic                 rx_drop,
  output logic [3:0]           led
);

  localparam int RES_W    = 2 * bit_width;
  localparam int TX_BYTES = res_bytes(bit_width);
  localparam int TXC_W    = $clog2(TX_BYTES);

  sched_state_t state_q, state_d;
  send_phase_t  phase_q, phase_d;

  logic              frame_done;
  logic [RES_W-1:0]  res_shift;
  logic [TXC_W-1:0]  tx_cnt_q;
  logic              last_tx_byte;
  logic              last_bin;

  assign last_tx_byte = (tx_cnt_q == TXC_W'(TX_BYTES - 1));
  assign last_bin     = (res_rd_addr == LOGN'(N - 1));

  rx_sample_assembler #(
    .bit_width (bit_width),
    .N         (N),
    .LOGN      (LOGN)
  ) u_rx_asm (
    .clk        (CLK),
    .rst_n      (RST_N),
    .en         (state_q == S_LOAD),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .smp_idx    (smp_idx),
    .frame_done (frame_done)
  );

  // Frame state and send sub-phase registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      phase_q <= P_READ;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic for the frame sequence and the per-byte TX handshake, plus the LED map.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    led     = LED_IDLE;
    case (state_q)
      S_IDLE: begin
        led = LED_IDLE;
        if (enable) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        led = LED_LOAD;
        if (frame_done) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        led = LED_RUN;
        if (fft_done) begin
          state_d = S_SEND;
          phase_d = P_READ;
        end
      end
      S_SEND: begin
        led = LED_SEND;
        case (phase_q)
          P_READ:    phase_d = P_LATCH;
          P_LATCH:   phase_d = P_ISSUE;
          P_ISSUE:   if (!tx_busy) phase_d = P_WAIT_HI;
          P_WAIT_HI: if (tx_busy) phase_d = P_WAIT_LO;
          P_WAIT_LO: begin
            if (!tx_busy) begin
              if (!last_tx_byte) begin
                phase_d = P_ISSUE;
              end else begin
                phase_d = P_READ;
                if (last_bin) begin
                  state_d = S_IDLE;
                end
              end
            end
          end
          default:   phase_d = P_READ;
        endcase
      end
      default: begin
        state_d = S_IDLE;
        phase_d = P_READ;
      end
    endcase
  end

  // Registered strobes, result read addressing, result shift register and byte counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fft_start   <= 1'b0;
      rx_drop     <= 1'b0;
      res_rd_en   <= 1'b0;
      res_rd_addr <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      res_shift   <= '0;
      tx_cnt_q    <= '0;
    end else begin
      fft_start <= (state_q == S_LOAD) && frame_done;
      rx_drop   <= rx_valid && (state_q != S_LOAD);
      tx_start  <= 1'b0;
      res_rd_en <= 1'b0;

      if ((state_q == S_RUN) && fft_done) begin
        res_rd_en   <= 1'b1;
        res_rd_addr <= '0;
      end

      if (state_q == S_SEND) begin
        case (phase_q)
          P_LATCH: begin
            res_shift <= {res_re, res_im};
            tx_cnt_q  <= '0;
          end
          P_ISSUE: begin
            if (!tx_busy) begin
              tx_start  <= 1'b1;
              tx_byte   <= res_shift[RES_W-1 -: 8];
              res_shift <= {res_shift[RES_W-9:0], 8'h00};
            end
          end
          P_WAIT_LO: begin
            if (!tx_busy) begin
              if (!last_tx_byte) begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
              end else if (last_bin) begin
                res_rd_addr <= '0;
              end else begin
                res_rd_addr <= res_rd_addr + 1'b1;
                res_rd_en   <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized self-checking bench for fft_frame_scheduler with a queue-based reference model.
module tb_fft_frame_scheduler;

  localparam int BW = 24;
  localparam int NS = 16;
  localparam int LN = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          enable = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          fft_done = 1'b0;
  logic [BW-1:0] res_re = '0;
  logic [BW-1:0] res_im = '0;
  logic          tx_busy = 1'b0;

  logic          smp_valid;
  logic [BW-1:0] smp_data;
  logic [LN-1:0] smp_idx;
  logic          fft_start;
  logic          res_rd_en;
  logic [LN-1:0] res_rd_addr;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          rx_drop;
  logic [3:0]    led;

  fft_frame_scheduler #(.bit_width(BW), .N(NS), .LOGN(LN)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .enable      (enable),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_idx     (smp_idx),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .res_rd_en   (res_rd_en),
    .res_rd_addr (res_rd_addr),
    .res_re      (res_re),
    .res_im      (res_im),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .rx_drop     (rx_drop),
    .led         (led)
  );

  typedef struct {
    int            due;
    logic [BW-1:0] data;
    logic [LN-1:0] idx;
  } smp_exp_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  smp_exp_t   smp_q[$];
  int         drop_q[$];
  logic [7:0] tx_q[$];
  int         fft_due = -1;

  logic [BW-1:0] acc = '0;
  int            nbytes = 0;
  int            sidx = 0;

  int            busy_len = 1;
  int            busy_cnt = 0;
  bit            seen_hi = 1'b1;
  bit            rd_pend = 1'b0;
  logic [LN-1:0] rd_addr_q = '0;
  logic [BW-1:0] mem_re[NS];
  logic [BW-1:0] mem_im[NS];

  int            tx_frame_cnt = 0;
  logic [7:0]    tx_log[6];
  logic [BW-1:0] last_smp = '0;

  bit       exp_now;
  bit       drop_now;
  smp_exp_t e;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Compare every output event against the model, then play the FFT memory and UART transmitter.
  always @(negedge CLK) begin
    if (!RST_N) begin
      busy_cnt = 0;
      tx_busy  = 1'b0;
      seen_hi  = 1'b1;
      rd_pend  = 1'b0;
    end else begin
      checkOutput("led_onehot", 64'($onehot(led)), 64'd1);

      exp_now = (smp_q.size() > 0) && (smp_q[0].due == cyc);
      if (smp_valid || exp_now) begin
        checkOutput("smp_valid", 64'(smp_valid), 64'(exp_now));
        if (exp_now) begin
          e = smp_q.pop_front();
          if (smp_valid) begin
            checkOutput("smp_data", 64'(smp_data), 64'(e.data));
            checkOutput("smp_idx", 64'(smp_idx), 64'(e.idx));
          end
        end
      end
      if (smp_valid) last_smp = smp_data;

      if (fft_start || (cyc == fft_due)) begin
        checkOutput("fft_start", 64'(fft_start), 64'(cyc == fft_due));
      end

      drop_now = (drop_q.size() > 0) && (drop_q[0] == cyc);
      if (rx_drop || drop_now) begin
        checkOutput("rx_drop", 64'(rx_drop), 64'(drop_now));
        if (drop_now) void'(drop_q.pop_front());
      end

      if (tx_start) begin
        checkOutput("tx_handshake", 64'({tx_busy, seen_hi}), 64'd1);
        seen_hi = 1'b0;
        checkOutput("tx_expected", 64'(tx_q.size() > 0), 64'd1);
        if (tx_q.size() > 0) checkOutput("tx_byte", 64'(tx_byte), 64'(tx_q.pop_front()));
        if (tx_frame_cnt < 6) tx_log[tx_frame_cnt] = tx_byte;
        tx_frame_cnt++;
      end

      if (tx_start) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = (busy_cnt > 0);
      if (tx_busy) seen_hi = 1'b1;

      if (rd_pend) begin
        res_re = mem_re[rd_addr_q];
        res_im = mem_im[rd_addr_q];
      end else begin
        res_re = BW'($urandom);
        res_im = BW'($urandom);
      end
      rd_pend   = res_rd_en;
      rd_addr_q = res_rd_addr;
    end
  end

  // One byte strobe; accepted bytes feed the sample model, others are expected to be dropped.
  task automatic applyStimulus(input logic [7:0] b, input bit accept, input int gap);
    repeat (gap) @(negedge CLK);
    rx_valid = 1'b1;
    rx_byte  = b;
    if (accept) begin
      acc = {acc[BW-9:0], b};
      nbytes++;
      if (nbytes == BW / 8) begin
        smp_q.push_back('{due: cyc + 1, data: acc, idx: LN'(sidx)});
        if (sidx == NS - 1) fft_due = cyc + 2;
        sidx   = (sidx + 1) % NS;
        nbytes = 0;
      end
    end else begin
      drop_q.push_back(cyc + 1);
    end
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic runFrame(input int pattern, input int blen, input int gapmax);
    logic [7:0] b;
    int budget;
    int w;
    busy_len     = blen;
    tx_frame_cnt = 0;
    enable = 1'b1;
    @(negedge CLK);
    enable = 1'b0;
    for (int i = 0; i < 3 * NS; i++) begin
      case (pattern)
        0:       b = (i % 3 == 2) ? 8'h01 : 8'h00;
        1:       b = (i % 3 == 2) ? 8'hFE : 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (i > 0) repeat ($urandom_range(0, gapmax)) @(negedge CLK);
      if (pattern == 2 && i == 10) fft_done = 1'b1;
      applyStimulus(b, 1'b1, 0);
      fft_done = 1'b0;
    end
    while (cyc < fft_due) @(negedge CLK);
    checkOutput("run_led", 64'(led), 64'd4);
    if (pattern != 1) applyStimulus(8'hC3, 1'b0, 0);

    for (int k = 0; k < NS; k++) begin
      mem_re[k] = BW'($urandom);
      mem_im[k] = BW'($urandom);
    end
    if (pattern == 0) begin
      mem_re[0] = 24'h123456;
      mem_im[0] = 24'hABCDEF;
    end
    for (int k = 0; k < NS; k++) begin
      tx_q.push_back(mem_re[k][23:16]);
      tx_q.push_back(mem_re[k][15:8]);
      tx_q.push_back(mem_re[k][7:0]);
      tx_q.push_back(mem_im[k][23:16]);
      tx_q.push_back(mem_im[k][15:8]);
      tx_q.push_back(mem_im[k][7:0]);
    end

    repeat ($urandom_range(1, 5)) @(negedge CLK);
    fft_done = 1'b1;
    @(negedge CLK);
    fft_done = 1'b0;
    if (pattern == 2) applyStimulus(8'h3C, 1'b0, 0);

    budget = NS * 6 * (blen + 8) + 200;
    w = 0;
    while (tx_q.size() > 0 && w < budget) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("tx_drained", 64'(tx_q.size()), 64'd0);
    tx_q.delete();
    w = 0;
    while (tx_busy && w < budget) begin
      @(negedge CLK);
      w++;
    end
    repeat (3) @(negedge CLK);
    checkOutput("idle_led", 64'(led), 64'd1);
    checkOutput("tx_count", 64'(tx_frame_cnt), 64'd96);
    checkOutput("drops_done", 64'(drop_q.size()), 64'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_outputs",
                64'({smp_valid, smp_data, smp_idx, fft_start, res_rd_en, res_rd_addr,
                     tx_start, tx_byte, rx_drop}), 64'd0);
    checkOutput("reset_led", 64'(led), 64'd1);
    RST_N = 1'b1;
    @(negedge CLK);

    applyStimulus(8'h5A, 1'b0, 0);

    runFrame(0, 2, 0);
    checkOutput("frame1_first_bytes",
                64'({tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4], tx_log[5]}),
                64'h123456ABCDEF);

    runFrame(1, 100, 1);
    checkOutput("frame2_last_sample", 64'(last_smp), 64'hFFFFFE);

    runFrame(2, $urandom_range(1, 4), 2);

    enable = 1'b1;
    @(negedge CLK);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1, 0);
    RST_N   = 1'b0;
    acc     = '0;
    nbytes  = 0;
    sidx    = 0;
    fft_due = -1;
    @(negedge CLK);
    checkOutput("midreset_outputs",
                64'({smp_valid, smp_data, smp_idx, fft_start, res_rd_en, res_rd_addr,
                     tx_start, tx_byte, rx_drop}), 64'd0);
    checkOutput("midreset_led", 64'(led), 64'd1);
    RST_N = 1'b1;
    @(negedge CLK);

    runFrame(2, $urandom_range(1, 4), 1);

    repeat (5) @(negedge CLK);
    checkOutput("queues_empty", 64'(smp_q.size() + drop_q.size() + tx_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit reached with %0d checks done", tests);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
